ddr_cmd_decoder: RTL and testbench

- Device-side responder for the DDR command bus driven by the controller command state machine.
- Samples CS/RAS/CAS/WE/CKE each clock, decodes the command, and tracks the device state with timing counters.
- Flags protocol or timing violations and emits read/write burst strobes for the behavioural memory model and checkers.
- Sits on the far end of the command bus, in benches and the self-check harness.

---
 rtl/ddr_cmd_decoder.sv | 160 ++++++++++++++++
 tb/tb_ddr_cmd_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_decoder.sv
// ddr_cmd_decoder: device-side DDR command bus responder with timing tracking.
// Optional DDR_DEC_ERR_COUNT_EN adds a saturating illegal-event counter on err_count.
module ddr_cmd_decoder #(
    parameter int T_MRD   = 4,
    parameter int T_ZQ    = 6,
    parameter int T_RFC   = 8,
    parameter int T_RCD   = 3,
    parameter int T_RP    = 3,
    parameter int T_BURST = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS,
    input  logic       RAS,
    input  logic       CAS,
    input  logic       WE,
    input  logic       CKE,
    input  logic       AP,
    output logic [3:0] cmd_code,
    output logic       cmd_valid,
    output logic [3:0] state,
    output logic       illegal,
    output logic       rd_strobe,
    output logic       wr_strobe,
    output logic       busy,
    output logic [7:0] err_count
);
    typedef enum logic [3:0] {
        INIT, ZQCAL, IDLE, MRS_WAIT, REFRESH, ACTIVATING,
        BANK_ACTIVE, READING, WRITING, PRECHARGING, PWR_DOWN, SELF_REF
    } state_t;

    localparam logic [3:0] C_NOP = 4'd0, C_DESEL = 4'd1, C_ACT = 4'd2, C_READ = 4'd3,
        C_READ_AP = 4'd4, C_WRITE = 4'd5, C_WRITE_AP = 4'd6, C_PRE = 4'd7, C_REF = 4'd8,
        C_SRE = 4'd9, C_MRS = 4'd10, C_ZQCL = 4'd11, C_PDE = 4'd12, C_PDX = 4'd13;

    state_t     cur, nxt;
    logic [7:0] cnt, n_cnt;
    logic [3:0] dec, n_code;
    logic       ap_q, n_ap, n_valid, n_ill, ok, rw, is_cmd, enter;

    function automatic state_t target(input logic [3:0] c);
        state_t t;
        case (c)
            C_ACT:                t = ACTIVATING;
            C_READ, C_READ_AP:    t = READING;
            C_WRITE, C_WRITE_AP:  t = WRITING;
            C_PRE:                t = PRECHARGING;
            C_REF:                t = REFRESH;
            C_SRE:                t = SELF_REF;
            C_MRS:                t = MRS_WAIT;
            C_ZQCL:               t = ZQCAL;
            default:              t = IDLE;
        endcase
        return t;
    endfunction

    function automatic logic [7:0] load(input state_t s);
        logic [7:0] v;
        case (s)
            MRS_WAIT:          v = 8'(T_MRD - 1);
            ZQCAL:             v = 8'(T_ZQ - 1);
            REFRESH:           v = 8'(T_RFC - 1);
            ACTIVATING:        v = 8'(T_RCD - 1);
            PRECHARGING:       v = 8'(T_RP - 1);
            READING, WRITING:  v = 8'(T_BURST - 1);
            default:           v = 8'd0;
        endcase
        return v;
    endfunction

    always_comb begin
        dec = C_NOP;
        if (CS) dec = C_DESEL;
        else case ({RAS, CAS, WE})
            3'b111:  dec = C_NOP;
            3'b011:  dec = C_ACT;
            3'b101:  dec = AP ? C_READ_AP : C_READ;
            3'b100:  dec = AP ? C_WRITE_AP : C_WRITE;
            3'b010:  dec = C_PRE;
            3'b001:  dec = CKE ? C_REF : C_SRE;
            3'b000:  dec = C_MRS;
            default: dec = C_ZQCL;
        endcase
    end

    always_comb begin
        rw      = dec inside {C_READ, C_READ_AP, C_WRITE, C_WRITE_AP};
        is_cmd  = dec > C_DESEL;
        ok      = cur == INIT ? dec inside {C_MRS, C_ZQCL} :
                  cur == IDLE ? (CKE ? dec inside {C_ACT, C_PRE, C_REF, C_MRS, C_ZQCL} : dec == C_SRE) :
                  cur == BANK_ACTIVE ? (rw || dec == C_PRE) :
                  (cur == READING || cur == WRITING) ? (rw && cnt == 8'd0) : 1'b0;
        nxt     = cur;
        n_cnt   = cnt == 8'd0 ? 8'd0 : cnt - 8'd1;
        n_ap    = ap_q;
        n_code  = dec;
        n_valid = 1'b0;
        n_ill   = 1'b0;
        enter   = 1'b0;
        // Expiry is evaluated first so a legal command in the same cycle can override it.
        if (cnt == 8'd0) begin
            if (cur inside {ZQCAL, MRS_WAIT, REFRESH, PRECHARGING}) nxt = IDLE;
            else if (cur == ACTIVATING) nxt = BANK_ACTIVE;
            else if (cur inside {READING, WRITING}) begin
                nxt   = ap_q ? PRECHARGING : BANK_ACTIVE;
                enter = 1'b1;
            end
        end
        if (cur == PWR_DOWN || cur == SELF_REF) begin
            n_code  = CKE ? C_PDX : cmd_code;
            n_valid = CKE;
            if (CKE) nxt = IDLE;
        end else if (cur == IDLE && !CKE && !is_cmd) begin
            nxt     = PWR_DOWN;
            n_code  = C_PDE;
            n_valid = 1'b1;
        end else if ((!CKE && cur != IDLE) || (is_cmd && !ok)) begin
            n_ill = 1'b1;
        end else if (ok) begin
            nxt     = (dec == C_PRE && cur == IDLE) ? IDLE : target(dec);
            n_ap    = dec == C_READ_AP || dec == C_WRITE_AP;
            n_valid = 1'b1;
            enter   = 1'b1;
        end
        if (enter) n_cnt = load(nxt);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cur       <= INIT;
            cnt       <= 8'd0;
            ap_q      <= 1'b0;
            cmd_code  <= C_NOP;
            cmd_valid <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            cur       <= nxt;
            cnt       <= n_cnt;
            ap_q      <= n_ap;
            cmd_code  <= n_code;
            cmd_valid <= n_valid;
            illegal   <= n_ill;
        end
    end

`ifdef DDR_DEC_ERR_COUNT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) err_count <= 8'd0;
        else if (n_ill && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'd0;
`endif

    assign state     = cur;
    assign rd_strobe = cur == READING;
    assign wr_strobe = cur == WRITING;
    assign busy      = cnt != 8'd0;
endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// tb_ddr_cmd_decoder: scoreboard bench for ddr_cmd_decoder with a cycle-level reference model.
module tb_ddr_cmd_decoder;
    localparam int T_MRD = 4, T_ZQ = 6, T_RFC = 8, T_RCD = 3, T_RP = 3, T_BURST = 4;

    logic CLK = 1'b0, RESET = 1'b1, CS = 1'b1, RAS = 1'b1, CAS = 1'b1, WE = 1'b1, CKE = 1'b1, AP = 1'b0;
    logic [3:0] cmd_code, state;
    logic       cmd_valid, illegal, rd_strobe, wr_strobe, busy;
    logic [7:0] err_count;

    ddr_cmd_decoder dut (
        .CLK(CLK), .RESET(RESET), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE), .CKE(CKE), .AP(AP),
        .cmd_code(cmd_code), .cmd_valid(cmd_valid), .state(state), .illegal(illegal),
        .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .busy(busy), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    logic [20:0] q[$];
    logic [20:0] e, a;
    int vectors = 0, miscompares = 0;
    int m_st, m_left, m_code, m_err;
    bit m_ap;

    // cycles each timed state lasts; 0 for untimed states
    function automatic int dur(input int s);
        case (s)
            1: return T_ZQ;
            3: return T_MRD;
            4: return T_RFC;
            5: return T_RCD;
            7, 8: return T_BURST;
            9: return T_RP;
            default: return 0;
        endcase
    endfunction

    function automatic int decode(input logic [3:0] b, input logic cke, input logic ap);
        if (b[3]) return 1;
        case (b[2:0])
            3'b111: return 0;
            3'b011: return 2;
            3'b101: return ap ? 4 : 3;
            3'b100: return ap ? 6 : 5;
            3'b010: return 7;
            3'b001: return cke ? 8 : 9;
            3'b000: return 10;
            default: return 11;
        endcase
    endfunction

    function automatic int target(input int d);
        case (d)
            2: return 5;
            3, 4: return 7;
            5, 6: return 8;
            7: return 9;
            8: return 4;
            9: return 11;
            10: return 3;
            11: return 1;
            default: return 2;
        endcase
    endfunction

    task automatic push_exp(input bit valid, input bit ill);
        q.push_back({4'(m_st), 4'(m_code), valid, ill, m_st == 7, m_st == 8, m_left > 1, 8'(m_err)});
    endtask

    task automatic model_reset();
        m_st = 0; m_left = 0; m_code = 0; m_err = 0; m_ap = 0;
    endtask

    task automatic step(input logic [3:0] b, input logic cke, input logic ap);
        int  d = decode(b, cke, ap);
        bit  nopish = d <= 1;
        bit  rw = d >= 3 && d <= 6;
        int  nst = m_st;
        int  nleft = m_left > 0 ? m_left - 1 : 0;
        bit  valid = 0, ill = 0, allowed;
        if (dur(m_st) > 0 && m_left == 1) begin
            nst = m_st == 5 ? 6 : (m_st == 7 || m_st == 8) ? (m_ap ? 9 : 6) : 2;
            nleft = dur(nst);
        end
        if (m_st == 10 || m_st == 11) begin
            if (cke) begin nst = 2; m_code = 13; valid = 1; end
        end else begin
            m_code = d;
            allowed = m_st == 0 ? (d == 10 || d == 11) :
                      m_st == 2 ? (cke ? (d == 2 || d == 7 || d == 8 || d == 10 || d == 11) : d == 9) :
                      m_st == 6 ? (rw || d == 7) :
                      (m_st == 7 || m_st == 8) ? (rw && m_left == 1) : 0;
            if (!cke && m_st != 2) ill = 1;
            else if (m_st == 2 && !cke && nopish) begin nst = 10; m_code = 12; valid = 1; end
            else if (!nopish) begin
                if (!allowed) ill = 1;
                else begin
                    valid = 1;
                    nst = (m_st == 2 && d == 7) ? 2 : target(d);
                    nleft = dur(nst);
                    if (rw) m_ap = d == 4 || d == 6;
                end
            end
        end
`ifdef DDR_DEC_ERR_COUNT_EN
        if (ill && m_err < 255) m_err++;
`endif
        m_st = nst;
        m_left = nleft;
        push_exp(valid, ill);
    endtask

    task automatic drive(input logic [3:0] b, input logic cke, input logic ap);
        {CS, RAS, CAS, WE} = b;
        CKE = cke;
        AP = ap;
        step(b, cke, ap);
        @(negedge CLK);
    endtask

    task automatic nop(input int n);
        repeat (n) drive(4'b0111, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        {CS, RAS, CAS, WE} = 4'b0111;
        CKE = 1'b1;
        model_reset();
        repeat (2) begin
            push_exp(0, 0);
            @(negedge CLK);
        end
        RESET = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(posedge CLK);
                #1;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    a = {state, cmd_code, cmd_valid, illegal, rd_strobe, wr_strobe, busy, err_count};
                    vectors++;
                    if (a !== e)
                        begin
                            miscompares++;
                            $display("FAIL outputs t=%0t {st,code,v,ill,rd,wr,busy,err} got st=%0d code=%0d %b%b%b%b%b err=%0d expected st=%0d code=%0d %b%b%b%b%b err=%0d",
                                     $time, a[20:17], a[16:13], a[12], a[11], a[10], a[9], a[8], a[7:0],
                                     e[20:17], e[16:13], e[12], e[11], e[10], e[9], e[8], e[7:0]);
                        end
                end
            end
            begin
                @(negedge CLK);
                do_reset();
                drive(4'b0110, 1, 0); nop(7);
                drive(4'b0000, 1, 0); nop(5);
                drive(4'b0011, 1, 0); nop(4);
                drive(4'b0100, 1, 0); nop(5);
                drive(4'b0101, 1, 1); nop(8);
                drive(4'b0011, 1, 0); nop(4);
                drive(4'b0101, 1, 0); nop(3);
                drive(4'b0101, 1, 0); nop(8);
                drive(4'b0010, 1, 0); nop(4);
                drive(4'b0101, 1, 0); nop(1);
                drive(4'b0111, 0, 0);
                drive(4'b0011, 0, 0);
                drive(4'b0111, 1, 0);
                drive(4'b0001, 0, 0);
                drive(4'b0111, 0, 0);
                drive(4'b1111, 0, 0);
                nop(2);
                drive(4'b0011, 1, 0); nop(3);
                drive(4'b0100, 1, 0); nop(1);
                RESET = 1'b1;
                #1;
                vectors++;
                if (wr_strobe !== 1'b0 || state !== 4'd0) begin
                    miscompares++;
                    $display("FAIL async_reset got wr_strobe=%b state=%0d expected wr_strobe=0 state=0", wr_strobe, state);
                end
                do_reset();
                repeat (300) drive(4'b0101, 1, 0);
                do_reset();
                repeat (3000) drive({1'($urandom_range(7) == 0), 3'($urandom)}, 1'($urandom_range(11) != 0), 1'($urandom));
                nop(1);
                repeat (2) @(negedge CLK);
                vectors++;
                if (q.size() != 0) begin
                    miscompares++;
                    $display("FAIL drain got %0d pending expected 0", q.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        join
    end
endmodule
